// File: rtl/date_pkg.sv
// Shared types and constants for the keypad date loader: FSM states, error codes,
// entry-size defaults and the Gregorian leap-year rule.
package date_pkg;

    localparam int DEF_NDIG     = 8;
    localparam int DEF_MAX_YEAR = 9999;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_CONVERT = 3'd2,
        S_CHECK   = 3'd3,
        S_DONE    = 3'd4,
        S_FAIL    = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE       = 2'd0;
    localparam logic [1:0] ERR_BAD_DIGIT  = 2'd1;
    localparam logic [1:0] ERR_INCOMPLETE = 2'd2;
    localparam logic [1:0] ERR_RANGE      = 2'd3;

    function automatic logic is_leap(input logic [13:0] year);
        return ((year[1:0] == 2'b00) && ((year % 14'd100) != 14'd0))
            || ((year % 14'd400) == 14'd0);
    endfunction

endpackage

// File: rtl/date_entry_loader_month_days.sv
// Days in a month for a given year; an out-of-range month reports 0 days.
module month_days
    import date_pkg::*;
(
    input  logic [3:0]  month,
    input  logic [13:0] year,
    output logic [4:0]  days
);

    always_comb begin
        days = 5'd0;
        case (month)
            4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: days = 5'd31;
            4'd4, 4'd6, 4'd9, 4'd11:                    days = 5'd30;
            4'd2:    days = is_leap(year) ? 5'd29 : 5'd28;
            default: days = 5'd0;
        endcase
    end

endmodule

// File: rtl/date_entry_loader.sv
// Keypad front end for the calendar: buffers DDMMYYYY BCD digits, converts them to
// binary with a one-digit-per-cycle multiply-accumulate, validates, and strobes a load.
module date_entry_loader
    import date_pkg::*;
#(
    parameter int NDIG     = DEF_NDIG,
    parameter int MAX_YEAR = DEF_MAX_YEAR
) (
    input  logic        CLK_50,
    input  logic        nCR,
    input  logic        entry_start,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    input  logic        entry_commit,
    output logic        ready,
    output logic        load,
    output logic [4:0]  load_day,
    output logic [3:0]  load_month,
    output logic [13:0] load_year,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [2:0]  dbg_state
);

    localparam int CW = $clog2(NDIG + 1);
    localparam int IW = $clog2(NDIG);
    localparam logic [CW-1:0] FULL_COUNT = CW'(NDIG);
    localparam logic [IW-1:0] LAST_STEP  = IW'(NDIG - 1);
    localparam logic [IW-1:0] STEP_MONTH = IW'(2);
    localparam logic [IW-1:0] STEP_YEAR  = IW'(4);
    localparam logic [13:0]   YEAR_MAX   = 14'(MAX_YEAR);

    state_t               r_state;
    state_t               w_next_state;
    logic [NDIG-1:0][3:0] r_buf;
    logic [CW-1:0]        r_count;
    logic [IW-1:0]        r_step;
    logic [13:0]          r_acc_day;
    logic [13:0]          r_acc_month;
    logic [13:0]          r_acc_year;
    logic                 r_bad;
    logic                 r_start_pend;
    logic [4:0]           r_load_day;
    logic [3:0]           r_load_month;
    logic [13:0]          r_load_year;
    logic [1:0]           r_err_code;

    logic                 w_start;
    logic                 w_restart;
    logic [3:0]           w_digit;
    logic [4:0]           w_days;
    logic                 w_range_bad;
    logic [1:0]           w_fail_code;

    // acc*10 + digit without a multiplier
    function automatic logic [13:0] bcd_mac(input logic [13:0] acc, input logic [3:0] d);
        return (acc << 3) + (acc << 1) + {10'd0, d};
    endfunction

    // An entry_start seen in DONE/FAIL is remembered and acted on from IDLE.
    assign w_start   = entry_start | r_start_pend;
    assign w_restart = ((r_state == S_IDLE) && w_start)
                    || (entry_start && ((r_state == S_COLLECT) || (r_state == S_CONVERT)
                                        || (r_state == S_CHECK)));
    assign w_digit   = r_buf[r_step];

    month_days u_month_days (
        .month (r_acc_month[3:0]),
        .year  (r_acc_year),
        .days  (w_days)
    );

    always_comb begin
        w_range_bad = (r_acc_month == 14'd0) || (r_acc_month > 14'd12)
                   || (r_acc_year == 14'd0)  || (r_acc_year > YEAR_MAX)
                   || (r_acc_day == 14'd0)   || (r_acc_day > {9'd0, w_days});
        w_fail_code = ERR_RANGE;
        if (r_state == S_COLLECT) begin
            w_fail_code = ERR_INCOMPLETE;
        end else if (r_bad) begin
            w_fail_code = ERR_BAD_DIGIT;
        end
    end

    always_ff @(posedge CLK_50 or negedge nCR) begin
        if (!nCR) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_next_state = S_COLLECT;
            end
            S_COLLECT: begin
                if (entry_start) begin
                    w_next_state = S_COLLECT;
                end else if (entry_commit) begin
                    w_next_state = (r_count == FULL_COUNT) ? S_CONVERT : S_FAIL;
                end
            end
            S_CONVERT: begin
                if (entry_start) begin
                    w_next_state = S_COLLECT;
                end else if (r_step == LAST_STEP) begin
                    w_next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                if (entry_start) begin
                    w_next_state = S_COLLECT;
                end else if (r_bad || w_range_bad) begin
                    w_next_state = S_FAIL;
                end else begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            S_FAIL:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        ready = (r_state == S_IDLE) || (r_state == S_COLLECT);
        load  = (r_state == S_DONE);
        err   = (r_state == S_FAIL);
    end

    always_ff @(posedge CLK_50 or negedge nCR) begin
        if (!nCR) begin
            r_buf        <= '0;
            r_count      <= '0;
            r_step       <= '0;
            r_acc_day    <= 14'd0;
            r_acc_month  <= 14'd0;
            r_acc_year   <= 14'd0;
            r_bad        <= 1'b0;
            r_start_pend <= 1'b0;
            r_load_day   <= 5'd1;
            r_load_month <= 4'd1;
            r_load_year  <= 14'd1;
            r_err_code   <= ERR_NONE;
        end else begin
            r_start_pend <= entry_start && ((r_state == S_DONE) || (r_state == S_FAIL));
            if (w_restart) begin
                r_buf      <= '0;
                r_count    <= '0;
                r_err_code <= ERR_NONE;
            end else begin
                case (r_state)
                    S_COLLECT: begin
                        if (entry_commit) begin
                            r_step      <= '0;
                            r_acc_day   <= 14'd0;
                            r_acc_month <= 14'd0;
                            r_acc_year  <= 14'd0;
                            r_bad       <= 1'b0;
                        end else if (digit_valid && (r_count < FULL_COUNT)) begin
                            r_buf[r_count[IW-1:0]] <= digit;
                            r_count                <= r_count + 1'b1;
                        end
                    end
                    S_CONVERT: begin
                        if (w_digit > 4'd9) r_bad <= 1'b1;
                        if (r_step < STEP_MONTH) begin
                            r_acc_day <= bcd_mac(r_acc_day, w_digit);
                        end else if (r_step < STEP_YEAR) begin
                            r_acc_month <= bcd_mac(r_acc_month, w_digit);
                        end else begin
                            r_acc_year <= bcd_mac(r_acc_year, w_digit);
                        end
                        r_step <= r_step + 1'b1;
                    end
                    default: ;
                endcase
                if (w_next_state == S_FAIL) begin
                    r_err_code <= w_fail_code;
                end else if (w_next_state == S_DONE) begin
                    r_err_code   <= ERR_NONE;
                    r_load_day   <= r_acc_day[4:0];
                    r_load_month <= r_acc_month[3:0];
                    r_load_year  <= r_acc_year;
                end
            end
        end
    end

    assign load_day   = r_load_day;
    assign load_month = r_load_month;
    assign load_year  = r_load_year;
    assign err_code   = r_err_code;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_date_entry_loader.sv
// Bench for date_entry_loader: directed date entries, expected strobes queued at
// commit time and checked by an independent monitor on the falling clock edge.
module tb_date_entry_loader;

    logic        CLK_50;
    logic        nCR;
    logic        entry_start;
    logic        digit_valid;
    logic [3:0]  digit;
    logic        entry_commit;
    logic        ready;
    logic        load;
    logic [4:0]  load_day;
    logic [3:0]  load_month;
    logic [13:0] load_year;
    logic        err;
    logic [1:0]  err_code;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    // {is_load, code[1:0], day[4:0], month[3:0], year[13:0], latency[3:0]}
    logic [29:0] exp_q[$];
    time         t_q[$];
    int          m_day   = 1;
    int          m_month = 1;
    int          m_year  = 1;
    logic        prev_strobe = 1'b0;

    date_entry_loader dut (
        .CLK_50       (CLK_50),
        .nCR          (nCR),
        .entry_start  (entry_start),
        .digit_valid  (digit_valid),
        .digit        (digit),
        .entry_commit (entry_commit),
        .ready        (ready),
        .load         (load),
        .load_day     (load_day),
        .load_month   (load_month),
        .load_year    (load_year),
        .err          (err),
        .err_code     (err_code),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial begin
        CLK_50 = 1'b0;
        forever #5 CLK_50 = ~CLK_50;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic start_entry();
        entry_start = 1'b1;
        @(posedge CLK_50);
        #1 entry_start = 1'b0;
    endtask

    task automatic send_digit(input logic [3:0] d);
        digit_valid = 1'b1;
        digit       = d;
        @(posedge CLK_50);
        #1 digit_valid = 1'b0;
    endtask

    task automatic send_bcd(input logic [31:0] bcd);
        for (int i = 7; i >= 0; i--) send_digit(bcd[i*4 +: 4]);
    endtask

    // Commit and queue the expected strobe; failures keep the last loaded fields.
    task automatic commit_expect(input logic is_load, input logic [1:0] code,
                                 input int d, input int m, input int y);
        int lat;
        entry_commit = 1'b1;
        @(posedge CLK_50);
        lat = (!is_load && code == 2'd2) ? 1 : 10;
        if (is_load) begin
            m_day   = d;
            m_month = m;
            m_year  = y;
        end
        t_q.push_back($time);
        exp_q.push_back({is_load, code, 5'(m_day), 4'(m_month), 14'(m_year), 4'(lat)});
        #1;
        entry_commit = 1'b0;
        digit_valid  = 1'b0;
        if (lat == 10) check("ready_busy", {31'd0, ready}, 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge CLK_50);
            n++;
        end
        check("drain_pending", exp_q.size(), 32'd0);
        exp_q.delete();
        t_q.delete();
        repeat (2) @(posedge CLK_50);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"},    {31'd0, ready}, 32'd1);
        check({tag, "_load"},     {31'd0, load}, 32'd0);
        check({tag, "_err"},      {31'd0, err}, 32'd0);
        check({tag, "_err_code"}, {30'd0, err_code}, 32'd0);
        check({tag, "_day"},      {27'd0, load_day}, 32'd1);
        check({tag, "_month"},    {28'd0, load_month}, 32'd1);
        check({tag, "_year"},     {18'd0, load_year}, 32'd1);
        check({tag, "_state"},    {29'd0, dbg_state}, 32'd0);
    endtask

    task automatic full_entry(input logic [31:0] bcd, input logic is_load, input logic [1:0] code,
                              input int d, input int m, input int y);
        start_entry();
        send_bcd(bcd);
        commit_expect(is_load, code, d, m, y);
        drain();
    endtask

    // scoreboard monitor
    always @(negedge CLK_50) begin
        logic [29:0] e;
        time         tc;
        if (nCR && (load || err)) begin
            check("strobe_gap", {31'd0, prev_strobe}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe actual=load%0b/err%0b required=none", load, err);
            end else begin
                e  = exp_q.pop_front();
                tc = t_q.pop_front();
                check("strobe_kind",  {31'd0, load}, {31'd0, e[29]});
                check("strobe_excl",  {31'd0, load & err}, 32'd0);
                check("err_code",     {30'd0, err_code}, {30'd0, e[28:27]});
                check("load_day",     {27'd0, load_day}, {27'd0, e[26:22]});
                check("load_month",   {28'd0, load_month}, {28'd0, e[21:18]});
                check("load_year",    {18'd0, load_year}, {18'd0, e[17:4]});
                check("latency",      32'((($time - tc) + 5) / 10), {28'd0, e[3:0]});
                check("ready_strobe", {31'd0, ready}, 32'd0);
            end
        end
        prev_strobe = nCR && (load || err);
    end

    // stimulus
    initial begin
        nCR          = 1'b0;
        entry_start  = 1'b0;
        digit_valid  = 1'b0;
        digit        = 4'd0;
        entry_commit = 1'b0;
        repeat (2) @(posedge CLK_50);
        #1;
        check_reset_values("in_reset");
        nCR = 1'b1;
        @(posedge CLK_50);
        #1;
        check_reset_values("after_reset");

        full_entry(32'h29022024, 1'b1, 2'd0, 29, 2, 2024);
        full_entry(32'h29021900, 1'b0, 2'd3, 0, 0, 0);
        check("err_code_hold", {30'd0, err_code}, 32'd3);
        full_entry(32'h29022000, 1'b1, 2'd0, 29, 2, 2000);
        full_entry(32'h31040000, 1'b0, 2'd3, 0, 0, 0);
        full_entry(32'h120A2024, 1'b0, 2'd1, 0, 0, 0);
        full_entry(32'h01019999, 1'b1, 2'd0, 1, 1, 9999);
        full_entry(32'h00012020, 1'b0, 2'd3, 0, 0, 0);
        full_entry(32'h28021900, 1'b1, 2'd0, 28, 2, 1900);
        full_entry(32'h29021600, 1'b1, 2'd0, 29, 2, 1600);
        full_entry(32'h31092021, 1'b0, 2'd3, 0, 0, 0);

        // incomplete entry: five digits
        start_entry();
        for (int i = 0; i < 5; i++) send_digit(4'(i + 1));
        commit_expect(1'b0, 2'd2, 0, 0, 0);
        drain();

        // ninth digit is dropped
        start_entry();
        send_bcd(32'h12122023);
        send_digit(4'd9);
        commit_expect(1'b1, 2'd0, 12, 12, 2023);
        drain();

        // digit coinciding with commit is dropped, leaving seven digits
        start_entry();
        for (int i = 0; i < 7; i++) send_digit(4'd1);
        digit_valid = 1'b1;
        digit       = 4'd3;
        commit_expect(1'b0, 2'd2, 0, 0, 0);
        drain();

        // reset during CONVERT step 4
        start_entry();
        send_bcd(32'h15062023);
        entry_commit = 1'b1;
        @(posedge CLK_50);
        #1 entry_commit = 1'b0;
        repeat (4) @(posedge CLK_50);
        #1 nCR = 1'b0;
        #1;
        check_reset_values("mid_convert");
        m_day   = 1;
        m_month = 1;
        m_year  = 1;
        repeat (2) @(posedge CLK_50);
        #1 nCR = 1'b1;
        repeat (15) @(posedge CLK_50);
        #1;
        check("post_reset_state", {29'd0, dbg_state}, 32'd0);

        // entry_start beats commit: buffer cleared, no conversion
        start_entry();
        for (int i = 0; i < 4; i++) send_digit(4'd2);
        entry_start  = 1'b1;
        entry_commit = 1'b1;
        @(posedge CLK_50);
        #1;
        entry_start  = 1'b0;
        entry_commit = 1'b0;
        check("start_commit_state", {29'd0, dbg_state}, 32'd1);
        repeat (3) @(posedge CLK_50);
        #1;
        check("start_commit_ready", {31'd0, ready}, 32'd1);
        commit_expect(1'b0, 2'd2, 0, 0, 0);
        drain();

        full_entry(32'h31122023, 1'b1, 2'd0, 31, 12, 2023);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
